tbird_monitor: RTL and testbench

//   Receive-side checker for the six-lamp tail-light bus (lc,lb,la,ra,rb,rc) driven by the

---
 rtl/tbird_pkg.sv | 69 ++++++
 rtl/tbird_monitor_sat_counter.sv | 32 +++
 rtl/tbird_monitor.sv | 180 ++++++++++++++++++
 tb/tb_tbird_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tbird_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tbird_pkg
// Description : Shared encodings for the six-lamp tail-light bus
//               {lc,lb,la,ra,rb,rc}: legal lamp patterns, decoded mode,
//               monitor FSM states and pattern decode helpers. Used by both
//               the turn-signal sequencer and the receive-side monitor.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package tbird_pkg;

   typedef enum logic [5:0] {
      PAT_IDLE = 6'b000000,
      PAT_L1   = 6'b001000,
      PAT_L2   = 6'b011000,
      PAT_L3   = 6'b111000,
      PAT_R1   = 6'b000100,
      PAT_R2   = 6'b000110,
      PAT_R3   = 6'b000111,
      PAT_H1   = 6'b001100,
      PAT_H2   = 6'b011110,
      PAT_H3   = 6'b111111
   } lamp_pat_t;

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'd0,
      MODE_LEFT  = 2'd1,
      MODE_RIGHT = 2'd2,
      MODE_HAZ   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_RUN    = 2'd1,
      M_RESYNC = 2'd2
   } mon_state_t;

   // Sequence family of a pattern; illegal patterns decode as MODE_IDLE.
   function automatic mode_t pat_mode(input lamp_pat_t p);
      case (p)
         PAT_L1, PAT_L2, PAT_L3: pat_mode = MODE_LEFT;
         PAT_R1, PAT_R2, PAT_R3: pat_mode = MODE_RIGHT;
         PAT_H1, PAT_H2, PAT_H3: pat_mode = MODE_HAZ;
         default:                pat_mode = MODE_IDLE;
      endcase
   endfunction

   // Step number within the family; 0 for IDLE and illegal patterns.
   function automatic logic [1:0] pat_step(input lamp_pat_t p);
      case (p)
         PAT_L1, PAT_R1, PAT_H1: pat_step = 2'd1;
         PAT_L2, PAT_R2, PAT_H2: pat_step = 2'd2;
         PAT_L3, PAT_R3, PAT_H3: pat_step = 2'd3;
         default:                pat_step = 2'd0;
      endcase
   endfunction

   // True for any of the ten named patterns.
   function automatic logic pat_legal(input logic [5:0] p);
      case (p)
         PAT_IDLE, PAT_L1, PAT_L2, PAT_L3, PAT_R1,
         PAT_R2, PAT_R3, PAT_H1, PAT_H2, PAT_H3: pat_legal = 1'b1;
         default:                                pat_legal = 1'b0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/tbird_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter that sticks at all-ones.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (clears q)
//               inc  - increment request
//               q    - count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (rst)
         r_q <= '0;
      else if (inc && (r_q != {W{1'b1}}))
         r_q <= r_q + 1'b1;
   end

   assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/tbird_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tbird_monitor
// Description : Receive-side protocol checker for the tail-light bus. Decodes
//               mode/step from the sampled lamp pattern, flags illegal
//               patterns, successions and hold times, and counts completed
//               sequences per mode with saturating counters.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               lc,lb,la,ra,rb,rc  - lamp inputs (same clock domain)
//               mode, step         - decoded mode / step (registered)
//               done, err          - 1-clk completion / violation pulses
//               err_sticky         - latched violation, cleared by rst only
//               left_cnt, right_cnt, haz_cnt - completed sequence counts
// Revision    : 1.0 - initial release
// ============================================================================
module tbird_monitor
   import tbird_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int HOLD  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lc,
   input  logic             lb,
   input  logic             la,
   input  logic             ra,
   input  logic             rb,
   input  logic             rc,
   output logic [1:0]       mode,
   output logic [1:0]       step,
   output logic             done,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] left_cnt,
   output logic [CNT_W-1:0] right_cnt,
   output logic [CNT_W-1:0] haz_cnt
);

   localparam int HW = $clog2(HOLD + 1);
   localparam logic [HW-1:0] c_hold_max = HW'(HOLD);

   // Sampled pattern and its decode
   logic [5:0] w_pat;
   logic       w_legal;
   logic       w_is_idle;
   mode_t      w_pmode;
   logic [1:0] w_pstep;

   assign w_pat     = {lc, lb, la, ra, rb, rc};
   assign w_legal   = pat_legal(w_pat);
   assign w_is_idle = (w_pat == PAT_IDLE);
   assign w_pmode   = pat_mode(lamp_pat_t'(w_pat));
   assign w_pstep   = pat_step(lamp_pat_t'(w_pat));

   // State and output registers
   mon_state_t    r_state, w_state;
   mode_t         r_mode,  w_mode;
   logic [1:0]    r_step,  w_step;
   logic [HW-1:0] r_hold,  w_hold;
   logic          r_done,  w_done;
   logic          r_err,   w_err;
   logic          r_err_sticky;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= M_IDLE;
         r_mode       <= MODE_IDLE;
         r_step       <= 2'd0;
         r_hold       <= '0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_mode       <= w_mode;
         r_step       <= w_step;
         r_hold       <= w_hold;
         r_done       <= w_done;
         r_err        <= w_err;
         r_err_sticky <= r_err_sticky | w_err;
      end
   end

   always_comb begin
      w_state = r_state;
      w_mode  = r_mode;
      w_step  = r_step;
      w_hold  = r_hold;
      w_done  = 1'b0;
      w_err   = 1'b0;

      case (r_state)
         M_IDLE: begin
            if (!w_is_idle) begin
               if (w_legal && (w_pstep == 2'd1)) begin
                  w_state = M_RUN;
                  w_mode  = w_pmode;
                  w_step  = 2'd1;
                  w_hold  = HW'(1);
               end else begin
                  w_err = 1'b1;
               end
            end
         end

         M_RUN: begin
            if (w_legal && (w_pmode == r_mode) && (w_pstep == r_step)) begin
               // Repeat of the current pattern: allowed until HOLD samples seen
               if (r_hold < c_hold_max)
                  w_hold = r_hold + 1'b1;
               else
                  w_err = 1'b1;
            end else if (w_legal && (w_pmode == r_mode) &&
                         (w_pstep == r_step + 2'd1) && (r_hold == c_hold_max)) begin
               w_step = w_pstep;
               w_hold = HW'(1);
            end else if (w_is_idle && (r_step == 2'd3) && (r_hold == c_hold_max)) begin
               w_state = M_IDLE;
               w_mode  = MODE_IDLE;
               w_step  = 2'd0;
               w_hold  = '0;
               w_done  = 1'b1;
            end else begin
               w_err = 1'b1;
            end
         end

         M_RESYNC: begin
            if (w_is_idle)
               w_state = M_IDLE;
         end

         default: begin
            w_state = M_IDLE;
            w_mode  = MODE_IDLE;
            w_step  = 2'd0;
            w_hold  = '0;
         end
      endcase

      // Any violation drops decode; an IDLE offending sample already resyncs.
      if (w_err) begin
         w_mode  = MODE_IDLE;
         w_step  = 2'd0;
         w_hold  = '0;
         w_state = w_is_idle ? M_IDLE : M_RESYNC;
      end
   end

   // Completed-sequence counters, indexed LEFT/RIGHT/HAZ
   logic [2:0]       w_inc;
   logic [CNT_W-1:0] w_cnt [3];

   assign w_inc[0] = w_done && (r_mode == MODE_LEFT);
   assign w_inc[1] = w_done && (r_mode == MODE_RIGHT);
   assign w_inc[2] = w_done && (r_mode == MODE_HAZ);

   for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      sat_counter #(
         .W (CNT_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (w_inc[gi]),
         .q   (w_cnt[gi])
      );
   end

   assign mode       = r_mode;
   assign step       = r_step;
   assign done       = r_done;
   assign err        = r_err;
   assign err_sticky = r_err_sticky;
   assign left_cnt   = w_cnt[0];
   assign right_cnt  = w_cnt[1];
   assign haz_cnt    = w_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_tbird_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_tbird_monitor
// Description : Directed self-checking bench for tbird_monitor. Three
//               instances: default (CNT_W=8,HOLD=1), HOLD=2 and CNT_W=2.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tbird_monitor;

   localparam logic [5:0] c_idle = 6'b000000;
   localparam logic [5:0] c_l1   = 6'b001000;
   localparam logic [5:0] c_l2   = 6'b011000;
   localparam logic [5:0] c_l3   = 6'b111000;
   localparam logic [5:0] c_r1   = 6'b000100;
   localparam logic [5:0] c_r2   = 6'b000110;
   localparam logic [5:0] c_r3   = 6'b000111;
   localparam logic [5:0] c_h1   = 6'b001100;
   localparam logic [5:0] c_h2   = 6'b011110;
   localparam logic [5:0] c_h3   = 6'b111111;
   localparam logic [5:0] c_bad  = 6'b010000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] r_pat0 = 6'd0;
   logic [5:0] r_pat1 = 6'd0;
   logic [5:0] r_pat2 = 6'd0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Default instance
   logic [1:0] w_mode0, w_step0;
   logic       w_done0, w_err0, w_stk0;
   logic [7:0] w_lc0, w_rc0, w_hc0;

   tbird_monitor #(.CNT_W(8), .HOLD(1)) u_dut (
      .clk (clk), .rst (rst),
      .lc (r_pat0[5]), .lb (r_pat0[4]), .la (r_pat0[3]),
      .ra (r_pat0[2]), .rb (r_pat0[1]), .rc (r_pat0[0]),
      .mode (w_mode0), .step (w_step0), .done (w_done0), .err (w_err0),
      .err_sticky (w_stk0), .left_cnt (w_lc0), .right_cnt (w_rc0), .haz_cnt (w_hc0)
   );

   // HOLD=2 instance
   logic [1:0] w_mode1, w_step1;
   logic       w_done1, w_err1, w_stk1;
   logic [7:0] w_lc1, w_rc1, w_hc1;

   tbird_monitor #(.CNT_W(8), .HOLD(2)) u_dut_h2 (
      .clk (clk), .rst (rst),
      .lc (r_pat1[5]), .lb (r_pat1[4]), .la (r_pat1[3]),
      .ra (r_pat1[2]), .rb (r_pat1[1]), .rc (r_pat1[0]),
      .mode (w_mode1), .step (w_step1), .done (w_done1), .err (w_err1),
      .err_sticky (w_stk1), .left_cnt (w_lc1), .right_cnt (w_rc1), .haz_cnt (w_hc1)
   );

   // CNT_W=2 instance
   logic [1:0] w_mode2, w_step2;
   logic       w_done2, w_err2, w_stk2;
   logic [1:0] w_lc2, w_rc2, w_hc2;

   tbird_monitor #(.CNT_W(2), .HOLD(1)) u_dut_c2 (
      .clk (clk), .rst (rst),
      .lc (r_pat2[5]), .lb (r_pat2[4]), .la (r_pat2[3]),
      .ra (r_pat2[2]), .rb (r_pat2[1]), .rc (r_pat2[0]),
      .mode (w_mode2), .step (w_step2), .done (w_done2), .err (w_err2),
      .err_sticky (w_stk2), .left_cnt (w_lc2), .right_cnt (w_rc2), .haz_cnt (w_hc2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [5:0] p);
      r_pat0 = p;
      tick();
   endtask

   task automatic drive1(input logic [5:0] p);
      r_pat1 = p;
      tick();
   endtask

   task automatic drive2(input logic [5:0] p);
      r_pat2 = p;
      tick();
   endtask

   initial begin : main
      int ndone;
      logic [1:0] exp_cnt;

      rst = 1'b1;
      tick();
      tick();
      check("rst_mode", w_mode0, 0);
      check("rst_step", w_step0, 0);
      check("rst_flags", {w_done0, w_err0, w_stk0}, 0);
      check("rst_cnts", {w_lc0, w_rc0, w_hc0}, 0);
      rst = 1'b0;

      // Legal LEFT sequence
      drive0(c_idle); check("l_idle", {w_mode0, w_step0}, 4'b0000);
      drive0(c_l1);   check("l1", {w_mode0, w_step0, w_done0, w_err0}, 6'b01_01_0_0);
      drive0(c_l2);   check("l2", {w_mode0, w_step0, w_done0, w_err0}, 6'b01_10_0_0);
      drive0(c_l3);   check("l3", {w_mode0, w_step0, w_done0, w_err0}, 6'b01_11_0_0);
      drive0(c_idle); check("l_done", {w_mode0, w_step0, w_done0, w_err0}, 6'b00_00_1_0);
      check("l_cnt", w_lc0, 1);
      check("l_stk", w_stk0, 0);
      drive0(c_idle); check("l_done_pulse", w_done0, 0);

      // Illegal pattern, resync, then a clean RIGHT sequence
      drive0(c_bad);  check("bad_err", {w_err0, w_stk0, w_mode0}, 4'b1_1_00);
      drive0(c_l1);   check("resync_noerr", {w_err0, w_mode0, w_step0}, 5'b0_00_00);
      drive0(c_idle); check("resync_idle", w_err0, 0);
      drive0(c_r1);   check("r1", {w_mode0, w_step0}, 4'b10_01);
      drive0(c_r2);   check("r2", {w_mode0, w_step0}, 4'b10_10);
      drive0(c_r3);   check("r3", {w_mode0, w_step0}, 4'b10_11);
      drive0(c_idle); check("r_done", {w_done0, w_err0, w_stk0}, 3'b1_0_1);
      check("r_cnt", w_rc0, 1);

      // Skipped step
      drive0(c_h1);   check("h1", {w_mode0, w_step0}, 4'b11_01);
      drive0(c_h3);   check("h_skip_err", {w_err0, w_mode0, w_step0}, 5'b1_00_00);
      drive0(c_idle); check("h_skip_idle", w_err0, 0);

      // No IDLE gap between sequences: err on the second R1
      drive0(c_r1);
      drive0(c_r2);
      drive0(c_r3);   check("gap_r3", w_err0, 0);
      drive0(c_r1);   check("gap_err", {w_err0, w_done0, w_mode0}, 4'b1_0_00);
      drive0(c_idle); check("gap_cnt", w_rc0, 1);

      // HOLD=1: repeated pattern is too long
      drive0(c_l1);
      drive0(c_l1);   check("h1_long", w_err0, 1);
      drive0(c_idle);

      // Mid-sequence reset discards the partial sequence
      drive0(c_r1);
      r_pat0 = c_r2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_out", {w_mode0, w_step0, w_done0, w_err0, w_stk0}, 0);
      check("mrst_cnt", {w_lc0, w_rc0, w_hc0}, 0);
      drive0(c_idle); check("mrst_idle", {w_err0, w_mode0}, 0);
      drive0(c_r1);   check("mrst_r1", {w_mode0, w_step0}, 4'b10_01);
      drive0(c_r2);
      drive0(c_r3);
      drive0(c_idle); check("mrst_done", {w_done0, w_err0}, 2'b10);
      check("mrst_rcnt", w_rc0, 1);

      // HOLD=2 instance
      drive1(c_l1);   check("h2_l1a", {w_mode1, w_step1, w_err1}, 5'b01_01_0);
      drive1(c_l1);   check("h2_l1b", {w_mode1, w_step1, w_err1}, 5'b01_01_0);
      drive1(c_l2);   check("h2_l2a", {w_step1, w_err1}, 3'b10_0);
      drive1(c_l2);
      drive1(c_l3);
      drive1(c_l3);   check("h2_l3b", {w_step1, w_err1}, 3'b11_0);
      drive1(c_idle); check("h2_done", {w_done1, w_err1}, 2'b10);
      check("h2_cnt", w_lc1, 1);
      drive1(c_l1);
      drive1(c_l2);   check("h2_short", {w_err1, w_mode1}, 3'b1_00);
      drive1(c_idle);
      drive1(c_l1);
      drive1(c_l1);   check("h2_l1_ok", w_err1, 0);
      drive1(c_l1);   check("h2_long", w_err1, 1);
      drive1(c_idle); check("h2_cnt_end", w_lc1, 1);

      // CNT_W=2 saturation over five HAZ sequences
      ndone = 0;
      for (int k = 1; k <= 5; k++) begin
         drive2(c_h1);
         drive2(c_h2);
         drive2(c_h3);
         drive2(c_idle);
         if (w_done2) ndone++;
         exp_cnt = (k < 3) ? 2'(k) : 2'd3;
         check($sformatf("sat_cnt%0d", k), w_hc2, exp_cnt);
      end
      check("sat_done_n", ndone, 5);
      check("sat_err", w_stk2, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
